// File: rtl/mem_stage_access.sv
// MEM-stage load/store sequencer: issues req/ack data-memory transactions and drives the MEM/WB bundle.
// Optional MEM_TIMEOUT_EN macro: abort a WAIT that exceeds TIMEOUT_CYC cycles and pulse mem_err.
module mem_stage_access #(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned RD_W        = 5,
    parameter int unsigned DMEM_AW     = 16,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DATA_W-1:0]  MEM_ALUResult,
    input  logic [DATA_W-1:0]  MEM_WriteData,
    input  logic [RD_W-1:0]    MEM_rd,
    input  logic               MEM_RegWrite,
    input  logic               MEM_MemToReg,
    input  logic               MEM_MemWrite,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic [DATA_W-1:0]  dmem_rdata,
    input  logic               dmem_ack,
    output logic               stall,
    output logic               mem_err,
    output logic [DATA_W-1:0]  WB_Result,
    output logic [RD_W-1:0]    WB_rd,
    output logic               WB_RegWrite
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t              state_q,       state_d;
    logic                req_q,         req_d;
    logic                we_q,          we_d;
    logic [DMEM_AW-1:0]  addr_q,        addr_d;
    logic [DATA_W-1:0]   wdata_q,       wdata_d;
    logic [DATA_W-1:0]   baddr_q,       baddr_d;
    logic [RD_W-1:0]     rd_lat_q,      rd_lat_d;
    logic                rw_lat_q,      rw_lat_d;
    logic [DATA_W-1:0]   wb_result_q,   wb_result_d;
    logic [RD_W-1:0]     wb_rd_q,       wb_rd_d;
    logic                wb_regwrite_q, wb_regwrite_d;
    logic                memop;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]    cnt_q,         cnt_d;
    logic                mem_err_q,     mem_err_d;
`endif

    assign memop = MEM_MemToReg | MEM_MemWrite;

    // Next-state, latch and writeback selection
    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        baddr_d       = baddr_q;
        rd_lat_d      = rd_lat_q;
        rw_lat_d      = rw_lat_q;
        wb_result_d   = wb_result_q;
        wb_rd_d       = wb_rd_q;
        wb_regwrite_d = 1'b0;
        stall         = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d         = cnt_q;
        mem_err_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (memop) begin
                    stall    = 1'b1;
                    state_d  = WAIT;
                    req_d    = 1'b1;
                    we_d     = MEM_MemWrite;
                    addr_d   = MEM_ALUResult[DMEM_AW+2:3];
                    wdata_d  = MEM_WriteData;
                    baddr_d  = MEM_ALUResult;
                    rd_lat_d = MEM_rd;
                    rw_lat_d = MEM_RegWrite;
`ifdef MEM_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end else begin
                    wb_result_d   = MEM_ALUResult;
                    wb_rd_d       = MEM_rd;
                    wb_regwrite_d = MEM_RegWrite & (MEM_rd != '0);
                end
            end
            WAIT: begin
                if (dmem_ack) begin
                    // Ack has priority over a simultaneous timeout
                    state_d = IDLE;
                    req_d   = 1'b0;
                    wb_rd_d = rd_lat_q;
                    if (we_q) begin
                        wb_result_d = baddr_q;
                    end else begin
                        wb_result_d   = dmem_rdata;
                        wb_regwrite_d = rw_lat_q & (rd_lat_q != '0);
                    end
`ifdef MEM_TIMEOUT_EN
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d   = IDLE;
                    req_d     = 1'b0;
                    mem_err_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
`else
                end else begin
                    stall = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            req_q         <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            baddr_q       <= '0;
            rd_lat_q      <= '0;
            rw_lat_q      <= 1'b0;
            wb_result_q   <= '0;
            wb_rd_q       <= '0;
            wb_regwrite_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q         <= '0;
            mem_err_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            baddr_q       <= baddr_d;
            rd_lat_q      <= rd_lat_d;
            rw_lat_q      <= rw_lat_d;
            wb_result_q   <= wb_result_d;
            wb_rd_q       <= wb_rd_d;
            wb_regwrite_q <= wb_regwrite_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q         <= cnt_d;
            mem_err_q     <= mem_err_d;
`endif
        end
    end

    assign dmem_req    = req_q;
    assign dmem_we     = we_q;
    assign dmem_addr   = addr_q;
    assign dmem_wdata  = wdata_q;
    assign WB_Result   = wb_result_q;
    assign WB_rd       = wb_rd_q;
    assign WB_RegWrite = wb_regwrite_q;
`ifdef MEM_TIMEOUT_EN
    assign mem_err     = mem_err_q;
`else
    assign mem_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_access.sv
// Directed self-checking bench for mem_stage_access; inputs driven and outputs sampled on negedge.
module tb_mem_stage_access;

    logic        clk;
    logic        rst_n;
    logic [63:0] MEM_ALUResult;
    logic [63:0] MEM_WriteData;
    logic [4:0]  MEM_rd;
    logic        MEM_RegWrite;
    logic        MEM_MemToReg;
    logic        MEM_MemWrite;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [63:0] dmem_rdata;
    logic        dmem_ack;
    logic        stall;
    logic        mem_err;
    logic [63:0] WB_Result;
    logic [4:0]  WB_rd;
    logic        WB_RegWrite;

    int n_cmp = 0;
    int n_err = 0;

    mem_stage_access #(.DATA_W(64), .RD_W(5), .DMEM_AW(16), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .MEM_ALUResult(MEM_ALUResult), .MEM_WriteData(MEM_WriteData),
        .MEM_rd(MEM_rd), .MEM_RegWrite(MEM_RegWrite),
        .MEM_MemToReg(MEM_MemToReg), .MEM_MemWrite(MEM_MemWrite),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .stall(stall), .mem_err(mem_err),
        .WB_Result(WB_Result), .WB_rd(WB_rd), .WB_RegWrite(WB_RegWrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [63:0] alu, input logic [63:0] wd, input logic [4:0] rd,
                         input logic rw, input logic m2r, input logic mw);
        MEM_ALUResult = alu;
        MEM_WriteData = wd;
        MEM_rd        = rd;
        MEM_RegWrite  = rw;
        MEM_MemToReg  = m2r;
        MEM_MemWrite  = mw;
    endtask

    initial begin
        rst_n      = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        drive(64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("rst_req", dmem_req, 0);
        check("rst_wb_rw", WB_RegWrite, 0);
        check("rst_wb_res", WB_Result, 0);
        check("rst_err", mem_err, 0);
        rst_n = 1'b1;

        // ALU op
        @(negedge clk);
        drive(64'h1234, 64'h0, 5'd7, 1'b1, 1'b0, 1'b0);
        #1 check("alu_stall", stall, 0);
        @(negedge clk);
        check("alu_res", WB_Result, 64'h1234);
        check("alu_rd", WB_rd, 7);
        check("alu_rw", WB_RegWrite, 1);
        check("alu_stall2", stall, 0);
        check("alu_req", dmem_req, 0);
        drive(64'h0, 64'h0, 5'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("alu_rd0_rw", WB_RegWrite, 0);

        // Load, ack on 3rd WAIT cycle; upstream garbage while stalled must be ignored
        drive(64'h40, 64'h0, 5'd3, 1'b1, 1'b1, 1'b0);
        #1 check("ld_issue_stall", stall, 1);
        @(negedge clk);
        check("ld_w1_req", dmem_req, 1);
        check("ld_w1_we", dmem_we, 0);
        check("ld_w1_addr", dmem_addr, 16'h0008);
        check("ld_w1_stall", stall, 1);
        check("ld_w1_rw", WB_RegWrite, 0);
        drive(64'hFFFF_0000, 64'h1111, 5'd9, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("ld_w2_req", dmem_req, 1);
        check("ld_w2_addr", dmem_addr, 16'h0008);
        check("ld_w2_we", dmem_we, 0);
        check("ld_w2_stall", stall, 1);
        @(negedge clk);
        check("ld_w3_req", dmem_req, 1);
        drive(64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        dmem_ack   = 1'b1;
        dmem_rdata = 64'hDEADBEEF;
        #1 check("ld_ack_stall", stall, 0);
        @(negedge clk);
        dmem_ack = 1'b0;
        check("ld_done_req", dmem_req, 0);
        check("ld_res", WB_Result, 64'hDEADBEEF);
        check("ld_rd", WB_rd, 3);
        check("ld_rw", WB_RegWrite, 1);
        @(negedge clk);
        check("ld_after_rw", WB_RegWrite, 0);

        // Store, ack on 1st WAIT cycle; RegWrite set on a store must not write back
        drive(64'h18, 64'hA5A5, 5'd5, 1'b1, 1'b0, 1'b1);
        #1 check("st_issue_stall", stall, 1);
        @(negedge clk);
        check("st_req", dmem_req, 1);
        check("st_we", dmem_we, 1);
        check("st_addr", dmem_addr, 16'h0003);
        check("st_wdata", dmem_wdata, 64'hA5A5);
        drive(64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        dmem_ack = 1'b1;
        #1 check("st_ack_stall", stall, 0);
        @(negedge clk);
        dmem_ack = 1'b0;
        check("st_done_req", dmem_req, 0);
        check("st_rw", WB_RegWrite, 0);

        // Load to rd=0 with high and low address bits that must be ignored
        drive(64'hFFFF_0000_0008_0107, 64'h0, 5'd0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("ld0_addr", dmem_addr, 16'h0020);
        check("ld0_we", dmem_we, 0);
        drive(64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        dmem_ack   = 1'b1;
        dmem_rdata = 64'h77;
        @(negedge clk);
        dmem_ack = 1'b0;
        check("ld0_res", WB_Result, 64'h77);
        check("ld0_rw", WB_RegWrite, 0);

        // MemToReg and MemWrite both set: treated as store
        drive(64'h28, 64'h55, 5'd4, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        check("both_we", dmem_we, 1);
        check("both_addr", dmem_addr, 16'h0005);
        check("both_wdata", dmem_wdata, 64'h55);
        drive(64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        dmem_ack   = 1'b1;
        dmem_rdata = 64'h99;
        @(negedge clk);
        dmem_ack = 1'b0;
        check("both_rw", WB_RegWrite, 0);
        check("both_rd", WB_rd, 4);

        // Reset in the 2nd WAIT cycle, late ack after release
        drive(64'h40, 64'h0, 5'd3, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("rw_w1_req", dmem_req, 1);
        drive(64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rw_req", dmem_req, 0);
        check("rw_addr", dmem_addr, 0);
        check("rw_wdata", dmem_wdata, 0);
        check("rw_we", dmem_we, 0);
        check("rw_res", WB_Result, 0);
        check("rw_rd", WB_rd, 0);
        check("rw_rw", WB_RegWrite, 0);
        rst_n = 1'b1;
        @(negedge clk);
        dmem_ack   = 1'b1;
        dmem_rdata = 64'h1111;
        #1 check("late_ack_stall", stall, 0);
        @(negedge clk);
        dmem_ack = 1'b0;
        check("late_ack_rw", WB_RegWrite, 0);
        check("late_ack_res", WB_Result, 0);
        check("late_ack_req", dmem_req, 0);

`ifdef MEM_TIMEOUT_EN
        // Timeout with no ack: 4 WAIT cycles then abort
        drive(64'h80, 64'h0, 5'd2, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        drive(64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("to_w%0d_req", i), dmem_req, 1);
            #1 check($sformatf("to_w%0d_stall", i), stall, (i == 4) ? 1'b0 : 1'b1);
            @(negedge clk);
        end
        check("to_req", dmem_req, 0);
        check("to_err", mem_err, 1);
        check("to_rw", WB_RegWrite, 0);
        @(negedge clk);
        check("to_err_pulse", mem_err, 0);

        // Ack in the limit cycle wins
        drive(64'h80, 64'h0, 5'd2, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        drive(64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("tw_w4_req", dmem_req, 1);
        dmem_ack   = 1'b1;
        dmem_rdata = 64'hCAFE;
        @(negedge clk);
        dmem_ack = 1'b0;
        check("tw_err", mem_err, 0);
        check("tw_rw", WB_RegWrite, 1);
        check("tw_res", WB_Result, 64'hCAFE);
`else
        // Without timeout, WAIT persists until ack
        drive(64'h80, 64'h0, 5'd2, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        drive(64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        check("nt_req", dmem_req, 1);
        check("nt_stall", stall, 1);
        check("nt_err", mem_err, 0);
        dmem_ack   = 1'b1;
        dmem_rdata = 64'hCAFE;
        @(negedge clk);
        dmem_ack = 1'b0;
        check("nt_err2", mem_err, 0);
        check("nt_rw", WB_RegWrite, 1);
        check("nt_res", WB_Result, 64'hCAFE);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
